// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter sequencer.
package pc_pkg;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0080;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } pc_state_e;

    typedef enum logic [1:0] {
        SEQ  = 2'd0,
        BR   = 2'd1,
        JMP  = 2'd2,
        TRAP = 2'd3
    } pc_src_e;

    // Instructions are word aligned; any set low bit in a target is a fault.
    function automatic logic is_misaligned(input logic [1:0] lsbs);
        return lsbs != 2'b00;
    endfunction

endpackage

// File: rtl/next_pc_mux.sv
// Priority next-PC select: trap > jump > branch > sequential, with a
// misaligned jump/branch target turned into a trap redirect.
module next_pc_mux
    import pc_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] TRAP_VECTOR = ADDR_W'(TRAP_VECTOR_DEF)
) (
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic              trap,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] next_pc,
    output logic              misalign_trap
);

    pc_src_e src;

    // Pick the source, then map it to an address. Only the selected target
    // is alignment checked, so a bad branch target under a jump is harmless.
    always_comb begin
        src           = SEQ;
        misalign_trap = 1'b0;
        next_pc       = pc_plus4;
        if (trap) begin
            src = TRAP;
        end else if (jump) begin
            if (is_misaligned(jump_target[1:0])) begin
                src           = TRAP;
                misalign_trap = 1'b1;
            end else begin
                src = JMP;
            end
        end else if (branch_taken) begin
            if (is_misaligned(branch_target[1:0])) begin
                src           = TRAP;
                misalign_trap = 1'b1;
            end else begin
                src = BR;
            end
        end
        case (src)
            SEQ:  next_pc = pc_plus4;
            BR:   next_pc = branch_target;
            JMP:  next_pc = jump_target;
            TRAP: next_pc = TRAP_VECTOR;
        endcase
    end

endmodule

// File: rtl/pcBlock.sv
// Program counter register with a load enable.
module pcBlock #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] d,
    output logic [ADDR_W-1:0] q
);

    // PC update: reset to the boot address, otherwise load only when enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VECTOR;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: BOOT/RUN/HALTED control, next-PC selection,
// trap EPC capture and the instruction-memory fetch handshake.
//
// Fetch handshake: while in RUN, imem_req stays high for the current pc.
// The instruction is accepted (commit) in any cycle where imem_req and
// imem_ready are both high; pc and epc change only on the edge ending such
// a cycle. With imem_ready low nothing advances and control inputs are
// ignored; imem_ready has no meaning while imem_req is low.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEF),
    parameter logic [ADDR_W-1:0] TRAP_VECTOR  = ADDR_W'(TRAP_VECTOR_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              imem_ready,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              trap,
    input  logic              halt,
    input  logic              resume,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              imem_req,
    output logic              commit,
    output logic [ADDR_W-1:0] epc,
    output logic              halted,
    output pc_state_e         dbg_state
);

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] next_pc;
    logic              misalign_trap;

    assign pc_plus4  = pc + ADDR_W'(4);
    assign dbg_state = state_q;

    next_pc_mux #(
        .ADDR_W      (ADDR_W),
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_mux (
        .pc_plus4      (pc_plus4),
        .trap          (trap),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .next_pc       (next_pc),
        .misalign_trap (misalign_trap)
    );

    pcBlock #(
        .ADDR_W       (ADDR_W),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc (
        .clk   (clk),
        .reset (reset),
        .load  (commit),
        .d     (next_pc),
        .q     (pc)
    );

    // Control state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs; commit is purely combinational.
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        commit   = 1'b0;
        halted   = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                imem_req = 1'b1;
                commit   = imem_ready;
                if (imem_ready && halt) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                halted = 1'b1;
                if (resume) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // Record the PC of an instruction that takes an explicit or alignment trap.
    always_ff @(posedge clk) begin
        if (reset) begin
            epc <= '0;
        end else if (commit && (trap || misalign_trap)) begin
            epc <= pc;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a table of per-cycle vectors plus a mid-stall
// reset sequence; post-edge pc/epc/state expectations go through exp_q.
module tb_pc_sequencer;
    import pc_pkg::*;

    localparam int W = 66;  // {pc, epc, state}

    typedef struct {
        logic        rdy;
        logic        br;
        logic [31:0] brt;
        logic        jmp;
        logic [31:0] jt;
        logic        trp;
        logic        hlt_in;
        logic        res;
        logic        req;
        logic        cmt;
        logic        hlt;
        logic [31:0] pc;
        logic [31:0] pc_nxt;
        logic [31:0] epc_nxt;
        logic [1:0]  st_nxt;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        imem_ready, branch_taken, jump, trap, halt, resume;
    logic [31:0] branch_target, jump_target;
    logic [31:0] pc, pc_plus4, epc;
    logic        imem_req, commit, halted;
    pc_state_e   dbg_state;

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .imem_ready    (imem_ready),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .trap          (trap),
        .halt          (halt),
        .resume        (resume),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .imem_req      (imem_req),
        .commit        (commit),
        .epc           (epc),
        .halted        (halted),
        .dbg_state     (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    vec_t         vecs[$];
    int           checks   = 0;
    int           failures = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_pop(input string name);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty got %0h expected entry", name, {pc, epc, 2'(dbg_state)});
        end else begin
            e = exp_q.pop_front();
            check(name, {pc, epc, 2'(dbg_state)}, e);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic add(input logic rdy, br, input logic [31:0] brt, input logic jmp,
                       input logic [31:0] jt, input logic trp, hlt_in, res,
                       input logic req, cmt, hlt, input logic [31:0] pcv, pc_nxt, epc_nxt,
                       input logic [1:0] st_nxt);
        vec_t v;
        v.rdy = rdy; v.br = br; v.brt = brt; v.jmp = jmp; v.jt = jt;
        v.trp = trp; v.hlt_in = hlt_in; v.res = res;
        v.req = req; v.cmt = cmt; v.hlt = hlt; v.pc = pcv;
        v.pc_nxt = pc_nxt; v.epc_nxt = epc_nxt; v.st_nxt = st_nxt;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        imem_ready    = v.rdy;
        branch_taken  = v.br;
        branch_target = v.brt;
        jump          = v.jmp;
        jump_target   = v.jt;
        trap          = v.trp;
        halt          = v.hlt_in;
        resume        = v.res;
    endtask

    task automatic idle_inputs();
        imem_ready = 1'b0; branch_taken = 1'b0; branch_target = '0; jump = 1'b0;
        jump_target = '0; trap = 1'b0; halt = 1'b0; resume = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] p4;
        reset = 1'b1;
        idle_inputs();
        // stimulus noise on control inputs while in reset must not matter
        imem_ready = 1'($urandom_range(0, 1));
        jump       = 1'($urandom_range(0, 1));
        repeat (2) @(posedge clk);
        #1;
        check("reset_pc",     {34'd0, pc},      {34'd0, 32'h0});
        check("reset_epc",    {34'd0, epc},     {34'd0, 32'h0});
        check("reset_state",  {64'd0, 2'(dbg_state)}, {64'd0, 2'(BOOT)});
        check("reset_outs",   {63'd0, imem_req, commit, halted}, '0);

        // cycle-by-cycle vector table starting in BOOT
        add(1,0,0,0,0,0,0,0, 0,0,0, 32'h0, 32'h0, 32'h0, RUN);
        add(1,0,0,0,0,0,0,0, 1,1,0, 32'h0, 32'h4, 32'h0, RUN);
        add(1,0,0,0,0,0,0,0, 1,1,0, 32'h4, 32'h8, 32'h0, RUN);
        add(1,0,0,0,0,0,0,0, 1,1,0, 32'h8, 32'hC, 32'h0, RUN);
        add(1,0,0,1,32'h10,0,0,0, 1,1,0, 32'hC, 32'h10, 32'h0, RUN);
        for (int i = 0; i < 3; i++)
            add(0,1,32'h60,1,32'h40,1,1,0, 1,0,0, 32'h10, 32'h10, 32'h0, RUN);
        add(1,0,0,1,32'h40,0,0,0, 1,1,0, 32'h10, 32'h40, 32'h0, RUN);
        add(1,0,0,1,32'h20,0,0,0, 1,1,0, 32'h40, 32'h20, 32'h0, RUN);
        add(1,1,32'h60,1,32'h40,1,0,0, 1,1,0, 32'h20, 32'h80, 32'h20, RUN);
        add(1,0,0,1,32'h30,0,0,0, 1,1,0, 32'h80, 32'h30, 32'h20, RUN);
        add(1,1,32'h42,0,0,0,0,0, 1,1,0, 32'h30, 32'h80, 32'h30, RUN);
        add(1,1,32'h50,0,0,0,0,0, 1,1,0, 32'h80, 32'h50, 32'h30, RUN);
        add(1,0,0,0,0,0,1,0, 1,1,0, 32'h50, 32'h54, 32'h30, HALTED);
        for (int i = 0; i < 5; i++)
            add(1,1,32'h60,1,32'h40,1,0,0, 0,0,1, 32'h54, 32'h54, 32'h30, HALTED);
        add(1,0,0,0,0,0,1,1, 0,0,1, 32'h54, 32'h54, 32'h30, RUN);
        add(1,0,0,0,0,0,0,0, 1,1,0, 32'h54, 32'h58, 32'h30, RUN);
        add(1,0,0,1,32'h101,0,0,0, 1,1,0, 32'h58, 32'h80, 32'h58, RUN);
        add(1,0,0,0,0,1,1,0, 1,1,0, 32'h80, 32'h80, 32'h80, HALTED);
        add(0,0,0,0,0,0,0,1, 0,0,1, 32'h80, 32'h80, 32'h80, RUN);
        add(1,0,0,1,32'hFFFF_FFFC,0,0,0, 1,1,0, 32'h80, 32'hFFFF_FFFC, 32'h80, RUN);
        add(1,0,0,0,0,0,0,0, 1,1,0, 32'hFFFF_FFFC, 32'h0, 32'h80, RUN);
        add(1,1,32'h2,1,32'h8,0,0,0, 1,1,0, 32'h0, 32'h8, 32'h80, RUN);

        reset = 1'b0;
        foreach (vecs[i]) begin
            drive(vecs[i]);
            #1;
            p4 = vecs[i].pc + 32'd4;
            check($sformatf("v%0d_pc", i),    {34'd0, pc},       {34'd0, vecs[i].pc});
            check($sformatf("v%0d_pc4", i),   {34'd0, pc_plus4}, {34'd0, p4});
            check($sformatf("v%0d_outs", i), {63'd0, imem_req, commit, halted},
                  {63'd0, vecs[i].req, vecs[i].cmt, vecs[i].hlt});
            exp_q.push_back({vecs[i].pc_nxt, vecs[i].epc_nxt, vecs[i].st_nxt});
            @(posedge clk);
            #1;
            sb_pop($sformatf("v%0d_next", i));
        end

        // reset asserted in the middle of a fetch stall
        idle_inputs();
        jump = 1'b1; jump_target = 32'h40;
        #1;
        check("stall_commit", {65'd0, commit}, '0);
        exp_q.push_back({32'h8, 32'h80, 2'(RUN)});
        @(posedge clk); #1;
        sb_pop("stall_hold");
        reset = 1'b1;
        exp_q.push_back({32'h0, 32'h0, 2'(BOOT)});
        @(posedge clk); #1;
        sb_pop("midstall_reset");
        check("midstall_outs", {63'd0, imem_req, commit, halted}, '0);
        reset = 1'b0; idle_inputs(); imem_ready = 1'b1;
        #1;
        check("boot_idle", {64'd0, imem_req, commit}, '0);
        exp_q.push_back({32'h0, 32'h0, 2'(RUN)});
        @(posedge clk); #1;
        sb_pop("boot_to_run");
        exp_q.push_back({32'h4, 32'h0, 2'(RUN)});
        @(posedge clk); #1;
        sb_pop("first_commit_after_reset");

        check("sb_drained", {{(W-32){1'b0}}, 32'(exp_q.size())}, '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
